// File: rtl/pc88_loader_sink_if.sv
// Loader byte handshake and byte-enabled SDRAM write port
// seen by pc88_loader_sink (slave) and its driver (master).
interface pc88_loader_sink_if #(
  parameter int ADR_W  = 19,
  parameter int MEM_AW = 24
);
  logic              ldr_oe;
  logic              ldr_wr;
  logic [ADR_W-1:0]  ldr_adr;
  logic [7:0]        ldr_wdat;
  logic              ldr_ack;
  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_wdat;
  logic [1:0]        mem_be;
  logic              mem_ack;

  modport master (
    output ldr_oe,
    output ldr_wr,
    output ldr_adr,
    output ldr_wdat,
    output mem_ack,
    input  ldr_ack,
    input  mem_req,
    input  mem_addr,
    input  mem_wdat,
    input  mem_be
  );

  modport slave (
    input  ldr_oe,
    input  ldr_wr,
    input  ldr_adr,
    input  ldr_wdat,
    input  mem_ack,
    output ldr_ack,
    output mem_req,
    output mem_addr,
    output mem_wdat,
    output mem_be
  );
endinterface

// File: rtl/pc88_loader_sink.sv
// Loader byte sink: writes each loader byte to SDRAM with a
// four-phase ack and keeps per-load count/checksum/status.
module pc88_loader_sink #(
  parameter int ADR_W   = 19,
  parameter int MEM_AW  = 24,
  parameter int BASE    = 0,
  parameter int SIZE    = 'h60000,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_sys,
  input  logic              reset,
  pc88_loader_sink_if.slave bus,
  output logic [19:0]       byte_cnt,
  output logic [15:0]       checksum,
  output logic              overflow,
  output logic              mem_err,
  output logic              loaded
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK
  } state_t;

  localparam int TW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);
  localparam logic [31:0] SIZE_L = 32'(SIZE);
  localparam logic [MEM_AW-1:0] BASE_W = MEM_AW'(BASE);

  state_t state;
  state_t state_d;

  logic [TW-1:0]     tmo_cnt;
  logic [MEM_AW-1:0] addr_q;
  logic [15:0]       wdat_q;
  logic [1:0]        be_q;
  logic              oe_q;

  logic in_rng;
  logic tmo_hit;
  logic oe_rise;
  logic oe_fall;
  logic latch;
  logic wr_done;
  logic wr_tmo;
  logic drop_ovf;

  assign in_rng  = 32'(bus.ldr_adr) < SIZE_L;
  assign tmo_hit = tmo_cnt == TMO;
  assign oe_rise = bus.ldr_oe & ~oe_q;
  assign oe_fall = ~bus.ldr_oe & oe_q;

  assign bus.mem_req  = state == WRITE;
  assign bus.ldr_ack  = state == ACK;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdat = wdat_q;
  assign bus.mem_be   = be_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d  = state;
    latch    = 1'b0;
    wr_done  = 1'b0;
    wr_tmo   = 1'b0;
    drop_ovf = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ldr_wr) begin
          latch = 1'b1;
          unique case (1'b1)
            !bus.ldr_oe: begin
              state_d = ACK;
            end
            bus.ldr_oe && in_rng: begin
              state_d = WRITE;
            end
            bus.ldr_oe && !in_rng: begin
              drop_ovf = 1'b1;
              state_d  = ACK;
            end
          endcase
        end
      end
      WRITE: begin
        // an ack on the expiry cycle still counts
        if (bus.mem_ack) begin
          wr_done = 1'b1;
          state_d = ACK;
        end else if (tmo_hit) begin
          wr_tmo  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!bus.ldr_wr) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmo_cnt <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      be_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      oe_q <= bus.ldr_oe;
      if (state == WRITE) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (latch) begin
        addr_q <= BASE_W
                + MEM_AW'(bus.ldr_adr[ADR_W-1:1]);
        wdat_q <= {2{bus.ldr_wdat}};
        be_q   <= bus.ldr_adr[0] ? 2'b10 : 2'b01;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      byte_cnt <= '0;
      checksum <= '0;
      overflow <= 1'b0;
      mem_err  <= 1'b0;
      loaded   <= 1'b0;
    end else begin
      if (oe_rise) begin
        byte_cnt <= '0;
        checksum <= '0;
        overflow <= 1'b0;
        mem_err  <= 1'b0;
        loaded   <= 1'b0;
      end
      // a write finishing as a new window opens is stale
      if (wr_done && !oe_rise) begin
        if (byte_cnt != '1) begin
          byte_cnt <= byte_cnt + 20'd1;
        end
        checksum <= checksum + {8'h00, wdat_q[7:0]};
      end
      if (drop_ovf) begin
        overflow <= 1'b1;
      end
      if (wr_tmo && !oe_rise) begin
        mem_err <= 1'b1;
      end
      if (oe_fall) begin
        loaded <= (byte_cnt != '0) || wr_done;
      end
    end
  end

endmodule

// File: doc/pc88_loader_sink.md
# pc88_loader_sink

Responder end of the ROM/image loader handshake inside the PC-8801 core. Accepts one byte at a time from the top-level loader (level request `ldr_wr`, held until acknowledged). Writes each byte into SDRAM through a byte-enabled 16-bit write port and returns a four-phase acknowledge. Also tracks the per-load byte count, checksum, range overflow and load completion for the boot logic.

## Interface
Parameters:
- `ADR_W`, 19: loader byte-address width.
- `MEM_AW`, 24: SDRAM word-address width.
- `BASE`, 0: SDRAM word offset added to every loader word address.
- `SIZE`, 'h60000: accepted byte range; bytes at `ldr_adr >= SIZE` are dropped.
- `TIMEOUT`, 1023: maximum cycles to wait for `mem_ack` before giving up.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ldr_oe` in 1: load window open (download active and not done).
- `ldr_wr` in 1: byte request, level; held high until `ldr_ack` is seen.
- `ldr_adr` in ADR_W: byte address, stable while `ldr_wr` is high.
- `ldr_wdat` in 8: byte data, stable while `ldr_wr` is high.
- `ldr_ack` out 1: acknowledge, high until `ldr_wr` is seen low.
- `mem_req` out 1: SDRAM write request, level.
- `mem_addr` out MEM_AW: equals `BASE + ldr_adr[ADR_W-1:1]`.
- `mem_wdat` out 16: `{byte,byte}`.
- `mem_be` out 2: `2'b10` if `ldr_adr[0]` is 1, else `2'b01`.
- `mem_ack` in 1: single-cycle pulse; the write has been accepted.
- `byte_cnt` out 20: bytes written in the current load.
- `checksum` out 16: modulo-2^16 sum of the written bytes.
- `overflow` out 1: sticky; at least one out-of-range byte was dropped.
- `mem_err` out 1: sticky; at least one write timed out.
- `loaded` out 1: last load finished with `byte_cnt` ≠ 0.

## Operation
- FSM states: IDLE, WRITE, ACK.
- **IDLE**
  - If `ldr_wr` is 1: latch address and data.
  - In-range with `ldr_oe`=1 → WRITE.
  - Out-of-range with `ldr_oe`=1 → set `overflow`, go to ACK, no memory write.
  - `ldr_oe`=0 → go to ACK, no write, no count. This prevents a loader hang.
- **WRITE**
  - `mem_req`=1; `mem_addr`, `mem_wdat`, `mem_be` are held from the latch.
  - Timeout counter runs.
  - On `mem_ack`: increment `byte_cnt`, add the byte to `checksum`, go to ACK.
  - If the counter reaches TIMEOUT with no ack: set `mem_err`, go to ACK, do not count the byte.
- **ACK**
  - `ldr_ack`=1.
  - When `ldr_wr` is sampled 0 → IDLE.
- Load window events:
  - Rising edge of `ldr_oe` clears `byte_cnt`, `checksum`, `overflow`, `mem_err` and `loaded`.
  - Falling edge of `ldr_oe` sets `loaded` if `byte_cnt` ≠ 0.
- Simultaneous `mem_ack` and timeout expiry: the ack wins; the byte is counted and `mem_err` is not set.
- `mem_ack` outside WRITE is ignored.
- `byte_cnt` saturates at 2^20-1. `checksum` wraps.

## Timing
- Reset (synchronous, one `clk_sys` edge):
  - State IDLE.
  - `ldr_ack`=0, `mem_req`=0, `mem_addr`=0, `mem_wdat`=0, `mem_be`=0.
  - `byte_cnt`=0, `checksum`=0, `overflow`=0, `mem_err`=0, `loaded`=0.
- Reset mid-operation drops `mem_req`/`ldr_ack` on the next edge. A write that was in flight is not counted.
- Write path:
  - `ldr_wr` sampled 1 in IDLE at edge N → `mem_req`=1 from N+1.
  - `mem_ack` at edge M → `mem_req`=0 and `ldr_ack`=1 from M+1.
  - `byte_cnt` and `checksum` update at M+1.
- Dropped or out-of-window byte: `ldr_ack`=1 from N+1.
- Release: `ldr_wr` sampled 0 at edge K → `ldr_ack`=0 and IDLE from K+1. A new request can be sampled at K+1.
- `ldr_ack` is never high in the same cycle as `mem_req`.
- Timeout: WRITE lasts at most TIMEOUT+1 cycles.

## Test plan
- **Single write.** Reset, then `ldr_oe`=1, `ldr_adr`=5, `ldr_wdat`=0xA5, `ldr_wr`=1, with `mem_ack` 3 cycles after `mem_req`.
  - Expect `mem_addr`=BASE+2, `mem_be`=2'b10, `mem_wdat`=0xA5A5.
  - Expect `ldr_ack` the cycle after `mem_ack`, then low the cycle after `ldr_wr` falls.
  - Expect `byte_cnt`=1, `checksum`=0x00A5.
- **Burst.** 256 bytes 0x00..0xFF at addresses 0..255, using the wrapper-style handshake (`ldr_wr` drops one cycle after `ldr_ack` is seen).
  - Expect 256 writes, `byte_cnt`=256, `checksum`=0x7F80.
  - Expect `loaded`=1 after `ldr_oe` falls.
- **Out of range.** `ldr_adr`=SIZE.
  - Expect no `mem_req`, `ldr_ack` at N+1, `overflow`=1, `byte_cnt` unchanged.
- **Timeout.** No `mem_ack`.
  - Expect `mem_req` high for TIMEOUT+1 cycles, then `ldr_ack`=1, `mem_err`=1, `byte_cnt`=0.
  - Then a `mem_ack` arriving on the exact expiry cycle is counted and `mem_err` stays 0.
- **Reset mid-WRITE.** Assert `reset` while `mem_req`=1.
  - Expect all outputs at reset values next cycle.
  - Expect the next request to work normally.
- **New load window.** Rising `ldr_oe` after a completed load.
  - Expect `byte_cnt`, `checksum`, `overflow`, `mem_err`, `loaded` all cleared.
  - Expect `ldr_wr` with `ldr_oe`=0 to be acknowledged with no write.
